dial_emu: RTL and testbench

- Parametrised multi-channel rotary dial / spinner emulator for arcade cores that read an absolute N-bit dial count from an input port.
- Generalises the single-channel fixed-speed dial with:
  - N channels
  - configurable output width
  - hold-to-accelerate button mode
  - analogue spinner mode that accumulates signed deltas and drains them at a bounded step rate
- Sits in the core top between joystick/keyboard/spinner decode and the game's input-port mux.

---
 rtl/dial_emu_pkg.sv | 39 +++
 rtl/dial_emu_channel.sv | 132 +++++++++++++
 rtl/dial_emu.sv | 63 ++++++
 tb/tb_dial_emu.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dial_emu_pkg.sv
// Shared types and arithmetic helpers for the dial/spinner emulator.
// Helpers work on int so a single definition serves any accumulator width.
package dial_emu_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } btn_state_t;

    // Symmetric clamp to +/-(2^(acc_w-1)-1): the most-negative code never appears.
    function automatic int sat_add(input int a, input int b, input int acc_w);
        int lim;
        int sum;
        int res;
        lim = (1 << (acc_w - 1)) - 1;
        sum = a + b;
        if (sum > lim) begin
            res = lim;
        end else if (sum < -lim) begin
            res = -lim;
        end else begin
            res = sum;
        end
        return res;
    endfunction

    function automatic int sign_step(input int v);
        int res;
        if (v > 0) begin
            res = 1;
        end else if (v < 0) begin
            res = -1;
        end else begin
            res = 0;
        end
        return res;
    endfunction

endpackage

// File: rtl/dial_emu_channel.sv
// One dial channel: button repeat FSM with acceleration, spinner accumulator
// draining one step per tick, and the wrapping dial counter.
module dial_channel
    import dial_emu_pkg::*;
#(
    parameter int WIDTH       = 5,
    parameter int SLOW_PERIOD = 16,
    parameter int FAST_PERIOD = 4,
    parameter int ACCEL_DEC   = 2,
    parameter int ACC_W       = 10
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_tick,
    input  logic              i_use_spinner,
    input  logic              i_move_left,
    input  logic              i_move_right,
    input  logic signed [7:0] i_spin_delta,
    input  logic              i_spin_stb,
    output logic [WIDTH-1:0]  o_dial,
    output logic              o_dir,
    output logic              o_step
);

    localparam int CNT_W = $clog2(SLOW_PERIOD + 1);
    localparam logic [CNT_W-1:0] P_SLOW = CNT_W'(SLOW_PERIOD);
    localparam logic [CNT_W-1:0] P_FAST = CNT_W'(FAST_PERIOD);

    btn_state_t              r_state, w_state_nx;
    logic [CNT_W-1:0]        r_cnt, w_cnt_nx;
    logic [CNT_W-1:0]        r_period, w_period_nx;
    logic [CNT_W-1:0]        w_period_dec;
    logic signed [ACC_W-1:0] r_acc, w_acc_nx;
    logic                    r_mode;
    logic [WIDTH-1:0]        r_dial;
    logic                    r_dir;
    logic                    r_step;
    logic                    w_one;
    logic                    w_step;
    logic                    w_step_up;
    logic                    w_drain;
    int                      w_sign;
    int                      w_delta;

    assign w_one = i_move_left ^ i_move_right;
    assign w_period_dec = (int'(r_period) - ACCEL_DEC <= FAST_PERIOD) ?
                          P_FAST : r_period - CNT_W'(ACCEL_DEC);

    always_comb begin
        w_state_nx  = r_state;
        w_cnt_nx    = r_cnt;
        w_period_nx = r_period;
        w_acc_nx    = r_acc;
        w_step      = 1'b0;
        w_step_up   = r_dir;
        w_sign      = sign_step(int'(r_acc));
        w_drain     = i_tick && (w_sign != 0);
        w_delta     = i_spin_stb ? int'(i_spin_delta) : 0;

        // A mode flip only cancels pending motion; the new mode acts next cycle.
        if (i_use_spinner != r_mode) begin
            w_state_nx  = ST_IDLE;
            w_period_nx = P_SLOW;
            w_acc_nx    = '0;
        end else if (r_mode) begin
            w_step    = w_drain;
            w_step_up = (w_sign > 0);
            w_acc_nx  = ACC_W'(sat_add(int'(r_acc), w_delta - (w_drain ? w_sign : 0), ACC_W));
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_one) begin
                        w_step      = 1'b1;
                        w_step_up   = i_move_right;
                        w_cnt_nx    = P_SLOW;
                        w_period_nx = P_SLOW;
                        w_state_nx  = ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (!w_one) begin
                        w_state_nx  = ST_IDLE;
                        w_period_nx = P_SLOW;
                    end else if (i_move_right != r_dir) begin
                        w_step      = 1'b1;
                        w_step_up   = i_move_right;
                        w_cnt_nx    = P_SLOW;
                        w_period_nx = P_SLOW;
                    end else if (i_tick) begin
                        if (r_cnt == CNT_W'(1)) begin
                            w_step      = 1'b1;
                            w_period_nx = w_period_dec;
                            w_cnt_nx    = w_period_dec;
                        end else begin
                            w_cnt_nx = r_cnt - 1'b1;
                        end
                    end
                end
                default: w_state_nx = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state  <= ST_IDLE;
            r_cnt    <= P_SLOW;
            r_period <= P_SLOW;
            r_acc    <= '0;
            r_mode   <= i_use_spinner;
            r_dial   <= '0;
            r_dir    <= 1'b0;
            r_step   <= 1'b0;
        end else begin
            r_state  <= w_state_nx;
            r_cnt    <= w_cnt_nx;
            r_period <= w_period_nx;
            r_acc    <= w_acc_nx;
            r_mode   <= i_use_spinner;
            r_step   <= w_step;
            if (w_step) begin
                r_dial <= w_step_up ? r_dial + 1'b1 : r_dial - 1'b1;
                r_dir  <= w_step_up;
            end
        end
    end

    assign o_dial = r_dial;
    assign o_dir  = r_dir;
    assign o_step = r_step;

endmodule

// File: rtl/dial_emu.sv
// Multi-channel rotary dial / spinner emulator: shared step-tick prescaler
// plus one independent dial_channel per output count.
module dial_emu #(
    parameter int CHANNELS    = 2,
    parameter int WIDTH       = 5,
    parameter int TICK_DIV    = 24000,
    parameter int SLOW_PERIOD = 16,
    parameter int FAST_PERIOD = 4,
    parameter int ACCEL_DEC   = 2,
    parameter int ACC_W       = 10
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [CHANNELS-1:0]       use_spinner,
    input  logic [CHANNELS-1:0]       move_left,
    input  logic [CHANNELS-1:0]       move_right,
    input  logic [CHANNELS*8-1:0]     spin_delta,
    input  logic [CHANNELS-1:0]       spin_stb,
    output logic [CHANNELS*WIDTH-1:0] dial_out,
    output logic [CHANNELS-1:0]       dial_dir,
    output logic [CHANNELS-1:0]       step_pulse
);

    localparam int PRESC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [PRESC_W-1:0] r_presc;
    logic               w_tick;

    assign w_tick = (r_presc == PRESC_W'(TICK_DIV - 1));

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_presc <= '0;
        end else if (w_tick) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + 1'b1;
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        dial_channel #(
            .WIDTH       (WIDTH),
            .SLOW_PERIOD (SLOW_PERIOD),
            .FAST_PERIOD (FAST_PERIOD),
            .ACCEL_DEC   (ACCEL_DEC),
            .ACC_W       (ACC_W)
        ) u_ch (
            .clk          (clk),
            .reset_n      (reset_n),
            .i_tick       (w_tick),
            .i_use_spinner(use_spinner[g]),
            .i_move_left  (move_left[g]),
            .i_move_right (move_right[g]),
            .i_spin_delta (spin_delta[g*8 +: 8]),
            .i_spin_stb   (spin_stb[g]),
            .o_dial       (dial_out[g*WIDTH +: WIDTH]),
            .o_dir        (dial_dir[g]),
            .o_step       (step_pulse[g])
        );
    end

endmodule

// File: tb/tb_dial_emu.sv
// Self-checking bench for dial_emu: vector table, hand-written corner
// sequences and randomized traffic against a cycle-level reference model.
module tb_dial_emu;
    import dial_emu_pkg::*;

    localparam int CH  = 2;
    localparam int W   = 5;
    localparam int TD  = 4;
    localparam int SP  = 4;
    localparam int FP  = 2;
    localparam int AD  = 1;
    localparam int AW  = 10;
    localparam int LIM = (1 << (AW - 1)) - 1;
    localparam int MOD = 1 << W;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [CH-1:0]     use_spinner;
    logic [CH-1:0]     move_left;
    logic [CH-1:0]     move_right;
    logic [CH*8-1:0]   spin_delta;
    logic [CH-1:0]     spin_stb;
    logic [CH*W-1:0]   dial_out;
    logic [CH-1:0]     dial_dir;
    logic [CH-1:0]     step_pulse;

    dial_emu #(
        .CHANNELS(CH), .WIDTH(W), .TICK_DIV(TD), .SLOW_PERIOD(SP),
        .FAST_PERIOD(FP), .ACCEL_DEC(AD), .ACC_W(AW)
    ) u_dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .use_spinner(use_spinner),
        .move_left  (move_left),
        .move_right (move_right),
        .spin_delta (spin_delta),
        .spin_stb   (spin_stb),
        .dial_out   (dial_out),
        .dial_dir   (dial_dir),
        .step_pulse (step_pulse)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: dial as integer modulo 2^W, repeat timing as "ticks
    // seen since the last step" against the current period, spinner as a
    // plain clamped integer.
    int m_cycle;
    int m_dial[CH], m_dir[CH], m_step[CH];
    int m_hold[CH], m_hdir[CH], m_period[CH], m_ticks[CH];
    int m_acc[CH], m_mode[CH];

    task automatic model_step();
        bit tick, one, st, up;
        int d;
        logic signed [7:0] sd;
        if (!reset_n) begin
            m_cycle = 0;
            for (int i = 0; i < CH; i++) begin
                m_dial[i] = 0; m_dir[i] = 0; m_step[i] = 0;
                m_hold[i] = 0; m_hdir[i] = 0; m_period[i] = SP; m_ticks[i] = 0;
                m_acc[i] = 0;  m_mode[i] = int'(use_spinner[i]);
            end
            return;
        end
        tick = ((m_cycle % TD) == TD - 1);
        m_cycle++;
        for (int i = 0; i < CH; i++) begin
            st = 0;
            up = 0;
            if (int'(use_spinner[i]) != m_mode[i]) begin
                m_mode[i] = int'(use_spinner[i]);
                m_acc[i] = 0; m_hold[i] = 0; m_period[i] = SP;
            end else if (m_mode[i] != 0) begin
                d = m_acc[i];
                if (spin_stb[i]) begin
                    sd = spin_delta[8*i +: 8];
                    d += sd;
                end
                if (tick && m_acc[i] != 0) begin
                    st = 1;
                    up = (m_acc[i] > 0);
                    d -= up ? 1 : -1;
                end
                m_acc[i] = (d > LIM) ? LIM : ((d < -LIM) ? -LIM : d);
            end else begin
                one = move_left[i] ^ move_right[i];
                if (m_hold[i] == 0) begin
                    if (one) begin
                        st = 1; up = move_right[i];
                        m_hold[i] = 1; m_period[i] = SP; m_ticks[i] = 0;
                    end
                end else if (!one) begin
                    m_hold[i] = 0; m_period[i] = SP;
                end else if (int'(move_right[i]) != m_hdir[i]) begin
                    st = 1; up = move_right[i];
                    m_period[i] = SP; m_ticks[i] = 0;
                end else if (tick) begin
                    m_ticks[i]++;
                    if (m_ticks[i] == m_period[i]) begin
                        st = 1; up = (m_hdir[i] != 0);
                        m_period[i] = (m_period[i] - AD < FP) ? FP : m_period[i] - AD;
                        m_ticks[i] = 0;
                    end
                end
                if (st) m_hdir[i] = up;
            end
            m_step[i] = st;
            if (st) begin
                m_dial[i] = up ? (m_dial[i] + 1) % MOD : (m_dial[i] + MOD - 1) % MOD;
                m_dir[i]  = up;
            end
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    bit chk_en = 1'b1;
    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            for (int i = 0; i < CH; i++) begin
                check($sformatf("model_ch%0d_dial", i), int'(dial_out[i*W +: W]), m_dial[i]);
                check($sformatf("model_ch%0d_dir", i), int'(dial_dir[i]), m_dir[i]);
                check($sformatf("model_ch%0d_step", i), int'(step_pulse[i]), m_step[i]);
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic align_tick();
        for (int k = 0; k < TD && (m_cycle % TD) != TD - 1; k++) @(negedge clk);
    endtask

    task automatic wait_step(input string name, input int ch, input int max_cyc, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!step_pulse[ch] && n < max_cyc);
        check({name, "_seen"}, int'(step_pulse[ch]), 1);
    endtask

    task automatic count_pulses(input int ch, input int ncyc, output int n, output int nup);
        n = 0;
        nup = 0;
        repeat (ncyc) begin
            @(negedge clk);
            if (step_pulse[ch]) begin
                n++;
                if (dial_dir[ch]) nup++;
            end
        end
    endtask

    typedef struct {
        logic l;
        logic r;
        int   exp_dial;
        int   exp_dir;
        int   exp_step;
    } vec_t;

    vec_t tbl[9];
    int   gaps[5];

    initial begin
        int n, nup, lat, g, saved;
        reset_n = 1'b0;
        use_spinner = '0; move_left = '0; move_right = '0;
        spin_delta = '0; spin_stb = '0;

        // Reset, then idle
        cycles(2);
        for (int i = 0; i < CH; i++) begin
            check("rst_dial", int'(dial_out[i*W +: W]), 0);
            check("rst_dir", int'(dial_dir[i]), 0);
            check("rst_step", int'(step_pulse[i]), 0);
        end
        reset_n = 1'b1;
        count_pulses(0, 100, n, nup);
        check("idle_pulses_ch0", n, 0);
        count_pulses(1, 1, n, nup);
        check("idle_pulses_ch1", n, 0);
        check("idle_dial", int'(dial_out), 0);
        check("idle_dir", int'(dial_dir), 0);

        // Single-cycle presses on channel 0 from IDLE, including wrap both ways
        tbl[0] = '{1'b0, 1'b1, 1,  1, 1};
        tbl[1] = '{1'b1, 1'b0, 0,  0, 1};
        tbl[2] = '{1'b1, 1'b0, 31, 0, 1};
        tbl[3] = '{1'b1, 1'b0, 30, 0, 1};
        tbl[4] = '{1'b0, 1'b1, 31, 1, 1};
        tbl[5] = '{1'b0, 1'b1, 0,  1, 1};
        tbl[6] = '{1'b1, 1'b1, 0,  1, 0};
        tbl[7] = '{1'b0, 1'b0, 0,  1, 0};
        tbl[8] = '{1'b1, 1'b0, 31, 0, 1};
        for (int k = 0; k < 9; k++) begin
            move_left[0] = tbl[k].l;
            move_right[0] = tbl[k].r;
            cycles(1);
            check($sformatf("vec%0d_dial", k), int'(dial_out[W-1:0]), tbl[k].exp_dial);
            check($sformatf("vec%0d_dir", k), int'(dial_dir[0]), tbl[k].exp_dir);
            check($sformatf("vec%0d_step", k), int'(step_pulse[0]), tbl[k].exp_step);
            move_left[0] = 1'b0;
            move_right[0] = 1'b0;
            cycles(1);
        end

        // Held right button: immediate step, then accelerating repeats
        gaps = '{16, 12, 8, 8, 8};
        align_tick();
        move_right[0] = 1'b1;
        wait_step("hold_first", 0, 2, lat);
        check("hold_first_latency", lat, 1);
        for (int k = 0; k < 5; k++) begin
            wait_step($sformatf("hold_gap%0d", k), 0, 40, g);
            check($sformatf("hold_gap%0d", k), g, gaps[k]);
        end
        check("hold_dial_after_6", int'(dial_out[W-1:0]), 5);
        cycles(147);
        check("hold_ch1_still", int'(dial_out[2*W-1:W]), 0);
        move_right[0] = 1'b0;
        cycles(2);

        // Direction reversal within a single cycle
        align_tick();
        move_left[0] = 1'b1;
        wait_step("rev_press", 0, 2, lat);
        check("rev_press_latency", lat, 1);
        cycles(5);
        align_tick();
        move_left[0] = 1'b0;
        move_right[0] = 1'b1;
        wait_step("rev_flip", 0, 2, lat);
        check("rev_flip_latency", lat, 1);
        check("rev_flip_dir", int'(dial_dir[0]), 1);
        wait_step("rev_gap", 0, 40, g);
        check("rev_gap", g, 16);

        // Both buttons: back to IDLE, no steps
        move_left[0] = 1'b1;
        cycles(1);
        check("both_idle", int'(u_dut.g_ch[0].u_ch.r_state), int'(ST_IDLE));
        count_pulses(0, 40, n, nup);
        check("both_no_steps", n, 0);
        move_left[0] = 1'b0;
        move_right[0] = 1'b0;
        cycles(2);

        // Spinner: +3 gives three increments, one per tick
        use_spinner[1] = 1'b1;
        cycles(2);
        spin_delta[15:8] = 8'd3;
        spin_stb[1] = 1'b1;
        cycles(1);
        spin_stb[1] = 1'b0;
        count_pulses(1, 40, n, nup);
        check("spin3_steps", n, 3);
        check("spin3_up", nup, 3);
        check("spin3_dial", int'(dial_out[2*W-1:W]), 3);

        // Five -128 strobes saturate at -511, then 511 decrements drain it
        spin_delta[15:8] = 8'h80;
        spin_stb[1] = 1'b1;
        cycles(5);
        spin_stb[1] = 1'b0;
        check("spin_sat_acc", int'(u_dut.g_ch[1].u_ch.r_acc), -LIM);
        count_pulses(1, LIM * TD + 40, n, nup);
        check("spin_drain_steps", n, LIM);
        check("spin_drain_up", nup, 0);
        check("spin_drain_acc", int'(u_dut.g_ch[1].u_ch.r_acc), 0);

        // Mode switch while motion is pending
        spin_delta[15:8] = 8'd20;
        spin_stb[1] = 1'b1;
        cycles(1);
        spin_stb[1] = 1'b0;
        cycles(2);
        saved = m_dial[1];
        use_spinner[1] = 1'b0;
        cycles(1);
        check("mode_acc_cleared", int'(u_dut.g_ch[1].u_ch.r_acc), 0);
        count_pulses(1, 40, n, nup);
        check("mode_off_steps", n, 0);
        use_spinner[1] = 1'b1;
        count_pulses(1, 40, n, nup);
        check("mode_back_steps", n, 0);
        check("mode_back_dial", int'(dial_out[2*W-1:W]), saved);

        // Reset while the spinner still has pending motion
        use_spinner[0] = 1'b1;
        cycles(2);
        spin_delta[7:0] = 8'd100;
        spin_stb[0] = 1'b1;
        cycles(1);
        spin_stb[0] = 1'b0;
        cycles(10);
        reset_n = 1'b0;
        cycles(1);
        reset_n = 1'b1;
        check("midrst_dial", int'(dial_out), 0);
        count_pulses(0, 60, n, nup);
        check("midrst_no_steps", n, 0);

        // Randomized traffic, checked cycle by cycle against the model
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < CH; i++) begin
                int r;
                if ($urandom_range(0, 299) == 0) use_spinner[i] = ~use_spinner[i];
                if ($urandom_range(0, 15) == 0) begin
                    r = $urandom_range(0, 3);
                    move_left[i] = r[1];
                    move_right[i] = r[0];
                end
                spin_stb[i] = ($urandom_range(0, 7) == 0);
                spin_delta[8*i +: 8] = 8'($urandom_range(0, 255));
            end
            cycles(1);
        end
        spin_stb = '0;
        cycles(4);

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
